hilo_muldiv: RTL and testbench

// - Iterative multiply/divide unit. This is the producer side of the HI/LO register pair.
// - Sits beside the EX stage. Accepts MULT/DIV operands, runs a 32-step shift-add
//   (multiply) or restoring (divide) loop, then issues one write pulse to HI and LO.
// - busy_o stalls the pipeline while an operation is in flight.

---
 rtl/hilo_muldiv_if.sv | 26 ++
 rtl/hilo_muldiv.sv | 178 +++++++++++++++++
 tb/tb_hilo_muldiv.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between the EX stage and the HI/LO multiply/divide unit.
// The pipeline side uses the master modport; the unit itself uses the slave modport.
interface hilo_muldiv_if;
    logic        start_i;
    logic        op_i;
    logic        signed_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        cancel_i;
    logic        busy_o;
    logic        done_o;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output start_i, op_i, signed_i, a_i, b_i, cancel_i,
        input  busy_o, done_o, hi_we, lo_we, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, signed_i, a_i, b_i, cancel_i,
        output busy_o, done_o, hi_we, lo_we, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative 32-bit multiply (shift-add) / divide (restoring) unit that
// produces one write to the HI/LO register pair per accepted operation.
// Optional feature macro: MULDIV_SIGNED_EN -- when defined, signed_i selects signed
// operation (magnitudes taken on entry, signs restored on the way into DONE); when
// undefined every operation is unsigned and signed_i is ignored.
module hilo_muldiv #(
    parameter int ITER = 32
) (
    input  logic         clk,
    input  logic         rst,
    hilo_muldiv_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    // MUL: {partial product, remaining multiplier}; DIV: {remainder, dividend/quotient}
    logic [63:0] acc_q;
    // MUL: multiplicand; DIV: divisor
    logic [31:0] opb_q;
    // Result staged during DONE; committed to hi_q/lo_q only if DONE is not cancelled
    logic [31:0] res_hi_q;
    logic [31:0] res_lo_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        last_step;
    logic [5:0]  cnt_d;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_sh;
    logic        div_ge;
    logic [63:0] div_next;

    logic [63:0] mul_res;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        show_res;

`ifdef MULDIV_SIGNED_EN
    logic a_neg;
    logic b_neg;
    // Sign of the product/quotient and sign of the remainder, captured at start
    logic res_neg_q;
    logic rem_neg_q;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    assign a_neg = bus.signed_i & bus.a_i[31];
    assign b_neg = bus.signed_i & bus.b_i[31];
    assign a_mag = a_neg ? neg32(bus.a_i) : bus.a_i;
    assign b_mag = b_neg ? neg32(bus.b_i) : bus.b_i;

    assign mul_res = res_neg_q ? neg64(mul_next) : mul_next;
    assign div_quo = res_neg_q ? neg32(div_next[31:0]) : div_next[31:0];
    assign div_rem = rem_neg_q ? neg32(div_next[63:32]) : div_next[63:32];
`else
    logic unused_signed;

    assign unused_signed = bus.signed_i;
    assign a_mag   = bus.a_i;
    assign b_mag   = bus.b_i;
    assign mul_res = mul_next;
    assign div_quo = div_next[31:0];
    assign div_rem = div_next[63:32];
`endif

    assign cnt_d     = cnt_q + 6'd1;
    assign last_step = (cnt_d == 6'(ITER));

    // One shift-add step: add multiplicand on multiplier bit0, then shift right with carry
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // One restoring step: shift {rem,quot} left, keep the trial difference if it fits
    assign div_sh   = {acc_q[63:32], acc_q[31]};
    assign div_ge   = (div_sh >= {1'b0, opb_q});
    assign div_next = div_ge ? {div_sh[31:0] - opb_q, acc_q[30:0], 1'b1}
                             : {div_sh[31:0],         acc_q[30:0], 1'b0};

    // Write strobes and write data are suppressed the moment a flush hits DONE
    assign show_res    = (state_q == S_DONE) && !bus.cancel_i;
    assign bus.busy_o  = (state_q != S_IDLE);
    assign bus.done_o  = show_res;
    assign bus.hi_we   = show_res;
    assign bus.lo_we   = show_res;
    assign bus.hi_o    = show_res ? res_hi_q : hi_q;
    assign bus.lo_o    = show_res ? res_lo_q : lo_q;

    // Control FSM plus iteration datapath; reset clears every register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MULDIV_SIGNED_EN
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i && !bus.cancel_i) begin
                        cnt_q <= '0;
`ifdef MULDIV_SIGNED_EN
                        res_neg_q <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
`endif
                        if (bus.op_i && (bus.b_i == 32'd0)) begin
                            // Divide-by-zero skips the loop and reports the raw dividend
                            res_hi_q <= bus.a_i;
                            res_lo_q <= 32'hFFFF_FFFF;
                            state_q  <= S_DONE;
                        end else if (bus.op_i) begin
                            acc_q   <= {32'd0, a_mag};
                            opb_q   <= b_mag;
                            state_q <= S_DIV;
                        end else begin
                            acc_q   <= {32'd0, b_mag};
                            opb_q   <= a_mag;
                            state_q <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (bus.cancel_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= mul_next;
                        cnt_q <= cnt_d;
                        if (last_step) begin
                            res_hi_q <= mul_res[63:32];
                            res_lo_q <= mul_res[31:0];
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DIV: begin
                    if (bus.cancel_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= div_next;
                        cnt_q <= cnt_d;
                        if (last_step) begin
                            res_hi_q <= div_rem;
                            res_lo_q <= div_quo;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    if (!bus.cancel_i) begin
                        hi_q <= res_hi_q;
                        lo_q <= res_lo_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Testbench for hilo_muldiv: directed vector table, hand-written cancel/reset/busy
// sequences and randomized operations checked against an arithmetic reference model.
module tb_hilo_muldiv;

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hilo_muldiv_if bus();

    hilo_muldiv #(.ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int pulse_cnt = 0;

    // Count write pulses seen at each active edge
    always @(posedge clk) begin
        if (bus.done_o) pulse_cnt <= pulse_cnt + 1;
    end

    typedef struct {
        logic        op;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: plain arithmetic on the operands
    function automatic void model(input logic op, input logic sgn, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] hi,
                                  output logic [31:0] lo);
        logic [63:0] p;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op) begin
            if (SIGNED_EN && sgn) p = 64'(sa * sb);
            else p = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (SIGNED_EN && sgn) begin
            q = sa / sb;
            r = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end else begin
            hi = a % b;
            lo = a / b;
        end
    endfunction

    // Called at a negedge just after the start-accepting edge plus kstart negedges
    task automatic wait_done(input string nm, input int kstart, input int p0,
                             input logic [31:0] ehi, input logic [31:0] elo, input int elat);
        int  lat;
        bit  got;
        lat = 0;
        got = 1'b0;
        for (int k = kstart + 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (k == 1) chk($sformatf("%s busy@T+1", nm), 64'(bus.busy_o), 64'd1);
            if (bus.done_o) begin
                got = 1'b1;
                lat = k;
                chk($sformatf("%s hi", nm), 64'(bus.hi_o), 64'(ehi));
                chk($sformatf("%s lo", nm), 64'(bus.lo_o), 64'(elo));
                chk($sformatf("%s we", nm), {62'd0, bus.hi_we, bus.lo_we}, 64'd3);
            end
        end
        if (!got) chk($sformatf("%s timeout", nm), 64'd0, 64'd1);
        chk($sformatf("%s latency", nm), 64'(lat), 64'(elat));
        @(negedge clk);
        chk($sformatf("%s busy low after", nm), 64'(bus.busy_o), 64'd0);
        chk($sformatf("%s held hi", nm), 64'(bus.hi_o), 64'(ehi));
        chk($sformatf("%s pulses", nm), 64'(pulse_cnt - p0), 64'd1);
    endtask

    task automatic launch(input logic op, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b);
        bus.start_i  = 1'b1;
        bus.op_i     = op;
        bus.signed_i = sgn;
        bus.a_i      = a;
        bus.b_i      = b;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.a_i     = ~a;
        bus.b_i     = ~b;
    endtask

    task automatic run_op(input string nm, input logic op, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int elat);
        int p0;
        launch(op, sgn, a, b);
        p0 = pulse_cnt;
        wait_done(nm, 0, p0, ehi, elo, elat);
    endtask

    vec_t tbl[10];

    initial begin
        logic [31:0] ehi, elo, old_hi, old_lo;
        int p0;

        tbl[0] = '{1'b0, 1'b0, 32'd7,          32'd6,          32'd0,          32'd42,         33};
        tbl[1] = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001,  33};
        tbl[2] = '{1'b1, 1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         33};
        tbl[3] = '{1'b1, 1'b0, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1};
        tbl[4] = '{1'b1, 1'b0, 32'd3,          32'd10,         32'd3,          32'd0,          33};
        tbl[5] = '{1'b1, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF,  33};
        tbl[6] = '{1'b0, 1'b0, 32'd0,          32'd12345,      32'd0,          32'd0,          33};
        tbl[7] = '{1'b0, 1'b0, 32'h8000_0000,  32'd2,          32'd1,          32'd0,          33};
        tbl[8] = '{1'b1, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'd1,          33};
        tbl[9] = '{1'b1, 1'b0, 32'h1234_5678,  32'h0000_1000,  32'h0000_0678,  32'h0001_2345,  33};

        rst          = 1'b1;
        bus.start_i  = 1'b0;
        bus.op_i     = 1'b0;
        bus.signed_i = 1'b0;
        bus.a_i      = '0;
        bus.b_i      = '0;
        bus.cancel_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(bus.busy_o), 64'd0);
        chk("reset done", {61'd0, bus.done_o, bus.hi_we, bus.lo_we}, 64'd0);
        chk("reset hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].sgn, tbl[i].a, tbl[i].b,
                   tbl[i].hi, tbl[i].lo, tbl[i].lat);

`ifdef MULDIV_SIGNED_EN
        run_op("s -7/2",   1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op("s -3*4",   1'b0, 1'b1, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 33);
        run_op("s min/-1", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
        run_op("s 7/-2",   1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
        run_op("s -7/0",   1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
`else
        run_op("u sgn ignored div", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 33);
        run_op("u sgn ignored mul", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd4, 32'd3, 32'hFFFF_FFF4, 33);
`endif

        // Cancel mid-divide: idle next cycle, no write, then a fresh start completes
        run_op("pre cancel", 1'b0, 1'b0, 32'd11, 32'd13, 32'd0, 32'd143, 33);
        old_hi = bus.hi_o;
        old_lo = bus.lo_o;
        launch(1'b1, 1'b0, 32'd100, 32'd7);
        p0 = pulse_cnt;
        repeat (10) @(negedge clk);
        bus.cancel_i = 1'b1;
        @(negedge clk);
        bus.cancel_i = 1'b0;
        chk("cancel busy", 64'(bus.busy_o), 64'd0);
        chk("cancel hilo", {bus.hi_o, bus.lo_o}, {old_hi, old_lo});
        chk("cancel pulses", 64'(pulse_cnt - p0), 64'd0);
        run_op("after cancel", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33);

        // Cancel together with start in IDLE: start dropped
        p0 = pulse_cnt;
        bus.cancel_i = 1'b1;
        launch(1'b0, 1'b0, 32'd3, 32'd3);
        bus.cancel_i = 1'b0;
        @(negedge clk);
        chk("cancel+start busy", 64'(bus.busy_o), 64'd0);
        repeat (3) @(negedge clk);
        chk("cancel+start pulses", 64'(pulse_cnt - p0), 64'd0);

        // Start while busy is ignored; operands are not re-latched
        launch(1'b0, 1'b0, 32'd7, 32'd6);
        p0 = pulse_cnt;
        repeat (5) @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i     = 32'd9;
        bus.b_i     = 32'd9;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done("busy start", 6, p0, 32'd0, 32'd42, 33);
        @(negedge clk);
        chk("busy start no relaunch", 64'(bus.busy_o), 64'd0);

        // Cancel during DONE: strobe suppressed, HI/LO keep old values
        launch(1'b0, 1'b0, 32'd9, 32'd9);
        p0 = pulse_cnt;
        repeat (33) @(negedge clk);
        chk("done-cancel busy", 64'(bus.busy_o), 64'd1);
        bus.cancel_i = 1'b1;
        #1;
        chk("done-cancel strobes", {61'd0, bus.done_o, bus.hi_we, bus.lo_we}, 64'd0);
        chk("done-cancel lo", 64'(bus.lo_o), 64'd42);
        @(negedge clk);
        bus.cancel_i = 1'b0;
        chk("done-cancel idle", 64'(bus.busy_o), 64'd0);
        chk("done-cancel held", {bus.hi_o, bus.lo_o}, {32'd0, 32'd42});
        chk("done-cancel pulses", 64'(pulse_cnt - p0), 64'd0);

        // Reset in the middle of an operation
        launch(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        p0 = pulse_cnt;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midop reset busy", 64'(bus.busy_o), 64'd0);
        chk("midop reset hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        repeat (35) @(negedge clk);
        chk("midop reset pulses", 64'(pulse_cnt - p0), 64'd0);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic        op, sgn;
            logic [31:0] a, b;
            op  = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            model(op, sgn, a, b, ehi, elo);
            run_op($sformatf("rnd%0d", i), op, sgn, a, b, ehi, elo,
                   (op && b == 32'd0) ? 1 : 33);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
